// File: rtl/font_fetch_sched_pkg.sv
// Shared widths, character codes and ROM slot-owner tags for the font fetch scheduler.
package font_pkg;

    localparam int unsigned CHAR_W = 2;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned FONT_W = 8;

    typedef enum logic [CHAR_W-1:0] {
        CH_BLANK = 2'd0,
        CH_I     = 2'd1,
        CH_S     = 2'd2,
        CH_A     = 2'd3
    } char_e;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rom_tag_t;

    function automatic logic [ADDR_W-1:0] font_addr(input logic [CHAR_W-1:0] ch,
                                                    input logic [ROW_W-1:0]  row);
        return {ch, row};
    endfunction

endpackage

// File: rtl/font_fetch_sched_tag_pipe.sv
// Shift of {valid, owner} tags matched to the font ROM read latency.
module rom_tag_pipe
    import font_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rom_tag_t tag_in,
    output rom_tag_t tag_out,
    output logic     disp_pending
);

    rom_tag_t stage_q [LAT];
    rom_tag_t stage_d [LAT];

    always_comb begin
        stage_d[0] = tag_in;
        for (int unsigned i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Includes the exiting stage: its data only reaches font_hold at the end of that cycle.
    always_comb begin
        disp_pending = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            disp_pending = disp_pending | (stage_q[i].valid && (stage_q[i].owner == OWN_DISP));
        end
    end

    always_comb begin
        tag_out = stage_q[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

endmodule

// File: rtl/font_fetch_sched.sv
// Font ROM slot arbiter: display prefetch per text cell with priority over host reads,
// plus row load and MSB-first serialisation into a registered text pixel.
module font_fetch_sched
    import font_pkg::*;
#(
    parameter int unsigned ROM_LAT      = 1,
    parameter int unsigned PREFETCH_COL = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [CHAR_W-1:0] next_char,
    input  logic [ROW_W-1:0]  next_row,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [FONT_W-1:0] host_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [FONT_W-1:0] rom_data,
    output logic              text_bit,
    output logic              fetch_late
);

    logic              disp_fetch, host_issue, cell_load;
    logic              host_exit, disp_exit, disp_pending;
    rom_tag_t          issue_tag, exit_tag;
    logic              unused_pixel_x_hi;

    logic [ADDR_W-1:0] rom_addr_d,   rom_addr_q;
    logic              host_busy_d,  host_busy_q;
    logic [FONT_W-1:0] host_data_d,  host_data_q;
    logic [FONT_W-1:0] font_hold_d,  font_hold_q;
    logic [FONT_W-1:0] cur_row_d,    cur_row_q;
    logic              text_bit_d,   text_bit_q;
    logic              fetch_late_d, fetch_late_q;

    always_comb begin
        unused_pixel_x_hi = ^pixel_x[9:3];

        disp_fetch = pixel_tick && (pixel_x[2:0] == 3'(PREFETCH_COL));
        host_issue = !disp_fetch && host_req && !host_busy_q;
        cell_load  = pixel_tick && (pixel_x[2:0] == 3'd7);

        issue_tag       = '0;
        issue_tag.valid = disp_fetch || host_issue;
        issue_tag.owner = disp_fetch ? OWN_DISP : OWN_HOST;

        host_exit = exit_tag.valid && (exit_tag.owner == OWN_HOST);
        disp_exit = exit_tag.valid && (exit_tag.owner == OWN_DISP);

        if (disp_fetch) begin
            rom_addr_d = font_addr(next_char, next_row);
        end else if (host_issue) begin
            rom_addr_d = host_addr;
        end else begin
            rom_addr_d = rom_addr_q;
        end
        // The address path is combinational, so reset has to gate it directly.
        rom_addr = rst ? rom_addr_d : '0;

        host_busy_d  = host_issue ? 1'b1 : (host_exit ? 1'b0 : host_busy_q);
        host_data_d  = host_exit ? rom_data : host_data_q;
        font_hold_d  = disp_exit ? rom_data : font_hold_q;
        cur_row_d    = cell_load ? font_hold_q : cur_row_q;
        fetch_late_d = fetch_late_q | (cell_load & disp_pending);
        // ~x[2:0] == 7 - x[2:0]: MSB first across the cell.
        text_bit_d   = pixel_tick ? (video_on & cur_row_q[~pixel_x[2:0]]) : text_bit_q;

        host_ack   = host_exit;
        host_data  = host_data_d;
        text_bit   = text_bit_q;
        fetch_late = fetch_late_q;
    end

    rom_tag_pipe #(
        .LAT(ROM_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst),
        .tag_in      (issue_tag),
        .tag_out     (exit_tag),
        .disp_pending(disp_pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q   <= '0;
            host_busy_q  <= 1'b0;
            host_data_q  <= '0;
            font_hold_q  <= '0;
            cur_row_q    <= '0;
            text_bit_q   <= 1'b0;
            fetch_late_q <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            host_busy_q  <= host_busy_d;
            host_data_q  <= host_data_d;
            font_hold_q  <= font_hold_d;
            cur_row_q    <= cur_row_d;
            text_bit_q   <= text_bit_d;
            fetch_late_q <= fetch_late_d;
        end
    end

endmodule

// File: tb/tb_font_fetch_sched.sv
// Directed bench: two schedulers (ROM latency 1 and 3) share stimulus, each with its own ROM model.
module tb_font_fetch_sched;
    import font_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pixel_tick, video_on, host_req;
    logic [9:0] pixel_x;
    logic [1:0] next_char;
    logic [3:0] next_row;
    logic [5:0] host_addr;

    logic       host_ack1, host_ack3, text_bit1, text_bit3, fetch_late1, fetch_late3;
    logic [7:0] host_data1, host_data3, rom_data1, rom_data3;
    logic [5:0] rom_addr1, rom_addr3;
    logic [7:0] rom3_pipe [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int gap    = 4;

    function automatic logic [7:0] font_model(input logic [5:0] a);
        logic [7:0] w;
        if (a == 6'h15) return 8'h18;
        w = {2'b00, a};
        return w * 8'd29 + 8'd7;
    endfunction

    always @(posedge clk) rom_data1 <= font_model(rom_addr1);
    always @(posedge clk) begin
        rom3_pipe[0] <= font_model(rom_addr3);
        rom3_pipe[1] <= rom3_pipe[0];
        rom3_pipe[2] <= rom3_pipe[1];
    end
    assign rom_data3 = rom3_pipe[2];

    font_fetch_sched #(.ROM_LAT(1), .PREFETCH_COL(6)) u_dut1 (
        .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .video_on(video_on), .pixel_x(pixel_x),
        .next_char(next_char), .next_row(next_row), .host_req(host_req), .host_addr(host_addr),
        .host_ack(host_ack1), .host_data(host_data1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .text_bit(text_bit1), .fetch_late(fetch_late1)
    );

    font_fetch_sched #(.ROM_LAT(3), .PREFETCH_COL(6)) u_dut3 (
        .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .video_on(video_on), .pixel_x(pixel_x),
        .next_char(next_char), .next_row(next_row), .host_req(host_req), .host_addr(host_addr),
        .host_ack(host_ack3), .host_data(host_data3), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .text_bit(text_bit3), .fetch_late(fetch_late3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic tick(input logic [9:0] x, input logic vo, input logic chk_en,
                        input logic exp1, input logic exp3);
        next_cyc();
        pixel_tick = 1'b1;
        pixel_x    = x;
        video_on   = vo;
        settle();
        if (x[2:0] == 3'd6) begin
            chk($sformatf("fetch_addr1_x%0d", x), 8'(rom_addr1), 8'({next_char, next_row}));
            chk($sformatf("fetch_addr3_x%0d", x), 8'(rom_addr3), 8'({next_char, next_row}));
        end
        next_cyc();
        pixel_tick = 1'b0;
        settle();
        if (chk_en) begin
            chk($sformatf("text1_x%0d", x), 8'(text_bit1), 8'(exp1));
            chk($sformatf("text3_x%0d", x), 8'(text_bit3), 8'(exp3));
        end
        repeat (gap - 2) next_cyc();
    endtask

    initial begin
        logic [7:0] bits, fresh, stale;

        rst = 1'b0; pixel_tick = 1'b0; video_on = 1'b0; pixel_x = '0;
        next_char = CH_I; next_row = 4'd5; host_req = 1'b1; host_addr = 6'h23;

        // Reset held with host request and fetch ticks active
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            pixel_tick = i[0];
            pixel_x    = 10'd6;
            settle();
            chk("rst_addr1", 8'(rom_addr1), 8'h00);
            chk("rst_addr3", 8'(rom_addr3), 8'h00);
            chk("rst_text1", 8'(text_bit1), 8'h00);
            chk("rst_ack1",  8'(host_ack1), 8'h00);
            chk("rst_ack3",  8'(host_ack3), 8'h00);
            chk("rst_late3", 8'(fetch_late3), 8'h00);
        end
        next_cyc();
        pixel_tick = 1'b0; host_req = 1'b0; rst = 1'b1;
        settle();
        chk("rst_hdata1", host_data1, 8'h00);

        // Host read into an idle ROM; request dropped before the latency-3 ack
        next_cyc(); host_req = 1'b1; host_addr = 6'h23; settle();
        chk("h_addr1", 8'(rom_addr1), 8'h23);
        chk("h_addr3", 8'(rom_addr3), 8'h23);
        chk("h_ack1_c0", 8'(host_ack1), 8'h00);
        next_cyc(); host_req = 1'b0; settle();
        chk("h_ack1_c1", 8'(host_ack1), 8'h01);
        chk("h_data1_c1", host_data1, font_model(6'h23));
        chk("h_ack3_c1", 8'(host_ack3), 8'h00);
        next_cyc(); settle();
        chk("h_ack1_c2", 8'(host_ack1), 8'h00);
        chk("h_data1_hold", host_data1, font_model(6'h23));
        chk("h_ack3_c2", 8'(host_ack3), 8'h00);
        next_cyc(); settle();
        chk("h_ack3_c3", 8'(host_ack3), 8'h01);
        chk("h_data3_c3", host_data3, font_model(6'h23));
        next_cyc(); settle();
        chk("h_ack3_c4", 8'(host_ack3), 8'h00);
        chk("h_data3_hold", host_data3, font_model(6'h23));

        // Display path, tick every 4 clk, then the same cells with video off
        gap = 4;
        bits = font_model(6'h15);
        tick(10'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(10'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(10'(8 + i), 1'b1, 1'b1, bits[7-i], bits[7-i]);
        for (int i = 0; i < 8; i++) tick(10'(16 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("late1_gap4", 8'(fetch_late1), 8'h00);
        chk("late3_gap4", 8'(fetch_late3), 8'h00);

        // Host request rises in the display fetch cycle
        next_cyc(); pixel_tick = 1'b1; pixel_x = 10'd30; video_on = 1'b1;
        host_req = 1'b1; host_addr = 6'h23; settle();
        chk("col_addr1_d0", 8'(rom_addr1), 8'h15);
        chk("col_addr3_d0", 8'(rom_addr3), 8'h15);
        next_cyc(); pixel_tick = 1'b0; settle();
        chk("col_addr1_d1", 8'(rom_addr1), 8'h23);
        chk("col_addr3_d1", 8'(rom_addr3), 8'h23);
        chk("col_ack1_d1", 8'(host_ack1), 8'h00);
        next_cyc(); host_req = 1'b0; settle();
        chk("col_ack1_d2", 8'(host_ack1), 8'h01);
        chk("col_data1_d2", host_data1, font_model(6'h23));
        chk("col_ack3_d2", 8'(host_ack3), 8'h00);
        next_cyc(); settle();
        chk("col_ack1_d3", 8'(host_ack1), 8'h00);
        chk("col_ack3_d3", 8'(host_ack3), 8'h00);
        next_cyc(); pixel_tick = 1'b1; pixel_x = 10'd31; settle();
        chk("col_ack3_d4", 8'(host_ack3), 8'h01);
        chk("col_data3_d4", host_data3, font_model(6'h23));
        next_cyc(); pixel_tick = 1'b0; settle();
        chk("col_ack3_d5", 8'(host_ack3), 8'h00);
        next_cyc(); next_cyc();
        for (int i = 0; i < 8; i++) tick(10'(32 + i), 1'b1, 1'b1, bits[7-i], bits[7-i]);

        // Tick every 2 clk: too tight for latency 3, so that unit loads the stale row
        gap = 2;
        next_char = CH_A; next_row = 4'd2;
        fresh = font_model(6'h32);
        stale = font_model(6'h15);
        tick(10'd46, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(10'd47, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("late1_gap2", 8'(fetch_late1), 8'h00);
        chk("late3_gap2", 8'(fetch_late3), 8'h01);
        for (int i = 0; i < 8; i++) tick(10'(48 + i), 1'b1, 1'b1, fresh[7-i], stale[7-i]);
        repeat (5) next_cyc();
        settle();
        chk("late3_sticky", 8'(fetch_late3), 8'h01);
        chk("late1_sticky", 8'(fetch_late1), 8'h00);

        // Reset one cycle after a host issue, request still held afterwards
        next_cyc(); host_req = 1'b1; host_addr = 6'h3E; settle();
        chk("rh_addr1_e0", 8'(rom_addr1), 8'h3E);
        next_cyc(); rst = 1'b0; settle();
        chk("rh_ack1_e1", 8'(host_ack1), 8'h00);
        chk("rh_addr1_e1", 8'(rom_addr1), 8'h00);
        chk("rh_data1_e1", host_data1, 8'h00);
        chk("rh_data3_e1", host_data3, 8'h00);
        chk("rh_late3_e1", 8'(fetch_late3), 8'h00);
        next_cyc(); rst = 1'b1; settle();
        chk("rh_addr1_e2", 8'(rom_addr1), 8'h3E);
        chk("rh_ack1_e2", 8'(host_ack1), 8'h00);
        next_cyc(); host_req = 1'b0; settle();
        chk("rh_ack1_e3", 8'(host_ack1), 8'h01);
        chk("rh_data1_e3", host_data1, font_model(6'h3E));
        chk("rh_ack3_e3", 8'(host_ack3), 8'h00);
        next_cyc(); settle();
        chk("rh_ack1_e4", 8'(host_ack1), 8'h00);
        chk("rh_ack3_e4", 8'(host_ack3), 8'h00);
        next_cyc(); settle();
        chk("rh_ack3_e5", 8'(host_ack3), 8'h01);
        chk("rh_data3_e5", host_data3, font_model(6'h3E));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/font_fetch_sched.md
Name: font_fetch_sched

Overview:
Scheduler and arbiter for the single shared font ROM (6-bit address {char[1:0], row[3:0]}, 8-bit row word, synchronous read).
- Display fetch: prefetches the next text cell's font row once per 8-pixel cell and serialises it into a registered text pixel stream.
- Host read: grants free ROM slots to a host/debug port over a req/ack handshake.
- Sits between the VGA sync/pixel counters and the fontrom instance. Replaces direct address driving by the character decoder.

Parameters:
ROM_LAT, 1, fontrom read latency in clk cycles (rom_data valid ROM_LAT cycles after rom_addr); legal range 1..3.
PREFETCH_COL, 6, pixel_x[2:0] value whose pixel_tick issues the display fetch for the next cell; legal range 0..6.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low (0 = reset).
pixel_tick  in  1  one-clk pixel enable from the sync generator.
video_on  in  1  active display area.
pixel_x  in  10  current pixel column, valid in the pixel_tick cycle.
next_char  in  2  character code of the next cell; sampled on the fetch tick.
next_row  in  4  font row for the next cell; sampled on the fetch tick.
host_req  in  1  host read request; held with host_addr until host_ack.
host_addr  in  6  host ROM address.
host_ack  out  1  one-cycle pulse; host_data is valid in this cycle.
host_data  out  8  ROM word for the host; holds its value until the next ack.
rom_addr  out  6  fontrom address, combinational from the arbiter.
rom_data  in  8  fontrom data.
text_bit  out  1  registered text pixel.
fetch_late  out  1  sticky error: a row load occurred with a display fetch still in flight.

Behaviour:
- Reset (rst=0, async): text_bit, host_ack, fetch_late, the tag pipeline, font_hold and cur_row all go to 0. host_data goes to 0x00. rom_addr is forced to 0. Any in-flight host read is discarded with no ack.
- Display fetch (disp_fetch): asserted when pixel_tick && pixel_x[2:0]==PREFETCH_COL.
  - Issued regardless of video_on, so the cell-0 fetch happens in blanking.
  - In that cycle rom_addr = {next_char, next_row}.
- Arbitration, one ROM slot per clk:
  - disp_fetch has absolute priority.
  - Otherwise the host owns the slot if host_req=1 and no host read is in flight; rom_addr = host_addr.
  - Otherwise the slot is idle: rom_addr holds its last value and no tag is issued.
- Tag pipeline: ROM_LAT stages carrying {valid, owner}.
  - On exit with owner=display: font_hold <= rom_data.
  - On exit with owner=host: host_data <= rom_data and host_ack=1 for exactly 1 cycle.
- Host handshake:
  - At most one host read is outstanding.
  - Ack latency is ROM_LAT cycles after issue, plus 1 cycle for every cycle the host is preempted by disp_fetch.
  - host_req is re-sampled in the cycle after host_ack. If it is still high, a new read of host_addr is issued (back-to-back reads are legal).
  - Dropping host_req before ack does not cancel the read; the ack still occurs.
- Row load and serialisation, evaluated on every pixel_tick with current pixel_x = X:
  - If X[2:0]==7: cur_row <= font_hold.
  - If a display tag is still in the pipeline at that load: fetch_late <= 1. fetch_late clears only on reset. cur_row loads the stale font_hold.
  - text_bit <= video_on & cur_row[7 - X[2:0]], using cur_row from before this tick's load.
  - Result: each cell's bits appear MSB first, registered, one clk after the tick that sampled the pixel.
- Timing constraint: the tick spacing from PREFETCH_COL to column 7 must be at least ROM_LAT+1 clk cycles; fetch_late flags violations.
- Simultaneous events: a host tag exit and a display fetch issue in the same cycle are independent and both proceed. Reset dominates everything.

Decomposition:
- Package font_pkg:
  - Widths: CHAR_W=2, ROW_W=4, ADDR_W=6, FONT_W=8.
  - Character codes: CH_BLANK=0, CH_I=1, CH_S=2, CH_A=3.
  - Owner encoding: OWN_DISP=0, OWN_HOST=1.
- Sub-module rom_tag_pipe (ROM_LAT-deep shift of {valid, owner}, async active-low reset) isolates the latency matching.
- The fontrom stays instantiated by the parent.

Test Plan:
1. Reset: hold rst=0 with host_req=1 and ticks running -> rom_addr=0, text_bit=0, host_ack=0, fetch_late=0 throughout.
2. Display path: ROM_LAT=1, tick every 4 clk, tick at pixel_x=6 with next_char=1, next_row=5 -> rom_addr=0x15 that cycle. Model returns 0x18. After the x=7 tick, ticks x=8..15 with video_on=1 -> text_bit 0,0,0,1,1,0,0,0. Same run with video_on=0 -> all 0.
3. Host idle read: host_req=1, host_addr=0x23, no fetch tick -> rom_addr=0x23 in the same cycle; host_ack for exactly 1 cycle, ROM_LAT cycles later, with host_data = model[0x23]; host_data holds afterwards.
4. Collision: host_req rises in the disp_fetch cycle -> rom_addr = display address that cycle, 0x23 the next cycle; ack arrives 1 cycle later than in test 3; font_hold and host_data both correct.
5. Late fetch: ROM_LAT=3, tick every 2 clk, fetch at x=6 -> fetch_late=1 at the x=7 tick, cur_row = previous font_hold; fetch_late stays 1 until reset.
6. Reset mid host read: rst pulsed low 1 cycle after host issue -> no host_ack; after release with host_req still high, a fresh read is issued and acked with correct data.
